multi_cycle_cpu: RTL and testbench
==================================

Name: multi_cycle_cpu

Overview:
Parametrised multi-cycle RV32I-subset core. It is the successor to the single-cycle CPU. It executes one instruction over several states (FETCH/DECODE/EXEC/MEM/WB) through a single unified memory port with a ready handshake, so instruction and data memories may stall. The register-file depth and reset vector are parametrised, and the core adds halt/trap and retire reporting for the system bench.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
NREGS, 32, architectural register count; legal values are 16 (RV32E-style) or 32.
XLEN, 32, data, address and register width; fixed at 32 (reserved for the 64-bit generation).

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-low reset (sampled on the rising edge of clk)
mem_req  out  1  memory request valid
mem_we  out  1  1 = store, 0 = fetch or load
mem_addr  out  32  byte address; always word-aligned when mem_req=1
mem_wdata  out  32  store data
mem_ready  in  1  transfer completes on an edge where mem_req=1 and mem_ready=1
mem_rdata  in  32  read data; valid on the completing edge
pc  out  32  address of the current instruction
retire  out  1  one-cycle pulse in WB of each completed instruction
halted  out  1  sticky; core stopped
illegal  out  1  sticky; the halt was caused by a trap

Behaviour:
- Reset (rst=0 at posedge, any state, including mid-request):
  - state=IDLE, pc=RESET_PC, all registers x0..x(NREGS-1)=0.
  - mem_req=0, mem_we=0, retire=0, halted=0, illegal=0.
  - Any outstanding request is abandoned.
- States and transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready; latch ir=mem_rdata; -> DECODE.
  - DECODE: read rs1=ir[19:15] and rs2=ir[24:20] into A/B; build the immediate (I/S/B/U/J formats, sign-extended); classify the opcode. -> EXEC, or -> HALT (ECALL 32'h0000_0073), or -> TRAP.
  - EXEC: ALU computes the result, branch condition, or effective address (A + imm). LW/SW -> MEM; all others -> WB.
  - MEM: mem_req=1; mem_addr=A+imm; for SW, mem_we=1 and mem_wdata=B. Address, write-enable and data stay stable until mem_ready. -> WB.
  - WB:
    - Write rd=ir[11:7] unless rd=0.
    - pc <= branch/jump target or pc+4.
    - retire=1 for this cycle only.
    - -> FETCH.
  - HALT: halted=1. pc stays at the ECALL address. mem_req=0. No register writes. Stays here until reset.
  - TRAP: halted=1 and illegal=1; otherwise the same as HALT.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target & ~1).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW (funct3=010 only).
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic: modulo 2^32, no overflow flag. Shifts use the low 5 bits of the shift amount. SLT is signed; SLTU is unsigned.
- Trap conditions (detected no later than EXEC; no memory access is issued and no register is written):
  - unknown opcode, funct3 or funct7;
  - any of rs1/rs2/rd >= NREGS;
  - LW/SW effective address with a nonzero value in bits [1:0];
  - taken branch or jump target with a nonzero value in bits [1:0].
- x0 always reads 0; writes to x0 are discarded.
- Latency with zero-wait memory (mem_ready=1 in the request cycle): 4 cycles per ALU, branch or jump instruction (FETCH, DECODE, EXEC, WB); 5 cycles for LW/SW. Each stall cycle adds 1.
- JAL/JALR write pc+4 (of the jump instruction) to rd before the pc update; rd=rs1 works correctly.

Test Plan:
- Reset, then ADDI x1,x0,5 / ADDI x2,x1,-7 / ECALL with zero-wait memory -> x1=5, x2=32'hFFFF_FFFE; retire pulses 4 cycles apart; halted=1 with pc=8; illegal=0.
- SW x2,0x40(x0) then LW x3,0x40(x0), with mem_ready held low for 3 cycles on each access -> mem_addr/mem_wdata stay stable while stalled; write of 32'hFFFF_FFFE observed; x3=32'hFFFF_FFFE; each instruction takes 8 cycles.
- Countdown loop: x1=3; ADDI x1,x1,-1; BNE x1,x0,-4 -> 3 BNE retires (2 taken); ends with x1=0 and pc=address after BNE.
- SRAI x4 on 32'h8000_0000 by 31, and SLTU 1 vs 32'hFFFF_FFFF -> x4=32'hFFFF_FFFF; SLTU result=1.
- Traps:
  - LW at address 0x41 -> no mem_req; halted=1, illegal=1.
  - NREGS=16 with ADD x20,x1,x2 -> same trap response.
  - Opcode 7'b1111111 -> same trap response.
- Reset asserted while FETCH is stalled (mem_ready=0) -> next cycle mem_req=0, pc=RESET_PC, registers=0; execution restarts cleanly; ADDI x0,x0,9 leaves x0=0.

Source files
------------

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/MEM/WB) over one ready-handshaked memory port; ports clk, rst (sync active-low), mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata, pc, retire, halted, illegal
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int NREGS = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
    OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [5:0] NR = 6'(NREGS);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  state_t state;
  logic [XLEN-1:0] ir, a, b, imm, res, npc;
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] imm_d, opb, alu, target, ea, wb_val;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd, sh;
  logic legal, use_rs1, use_rs2, use_rd, bad_reg, is_jal, is_jalr, is_br, is_ld, is_st;
  logic cond, taken, x_trap;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd = ir[11:7];
  assign is_jal = op == OP_JAL;
  assign is_jalr = op == OP_JALR;
  assign is_br = op == OP_BR;
  assign is_ld = op == OP_LD;
  assign is_st = op == OP_ST;
  // Legality and operand usage per format; register-range checks only apply to fields the format uses.
  always_comb begin
    legal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd = 1'b0;
    imm_d = {{20{ir[31]}}, ir[31:20]};
    case (op)
      OP_LUI, OP_AUIPC: begin legal = 1'b1; use_rd = 1'b1; imm_d = {ir[31:12], 12'b0}; end
      OP_JAL: begin legal = 1'b1; use_rd = 1'b1; imm_d = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}; end
      OP_JALR: begin legal = f3 == 3'b000; use_rs1 = 1'b1; use_rd = 1'b1; end
      OP_BR: begin legal = f3[2:1] != 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_d = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}; end
      OP_LD: begin legal = f3 == 3'b010; use_rs1 = 1'b1; use_rd = 1'b1; end
      OP_ST: begin legal = f3 == 3'b010; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]}; end
      OP_IMM: begin legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; end
      OP_REG: begin legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)); use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      default: ;
    endcase
  end
  assign bad_reg = (use_rs1 && {1'b0, rs1} >= NR) || (use_rs2 && {1'b0, rs2} >= NR) || (use_rd && {1'b0, rd} >= NR);
  assign opb = op == OP_REG ? b : imm;
  assign sh = opb[4:0];
  always_comb begin
    alu = a + opb;
    case (f3)
      3'b000: alu = (op == OP_REG && ir[30]) ? a - opb : a + opb;
      3'b001: alu = a << sh;
      3'b010: alu = {31'b0, $signed(a) < $signed(opb)};
      3'b011: alu = {31'b0, a < opb};
      3'b100: alu = a ^ opb;
      3'b101: alu = ir[30] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'b110: alu = a | opb;
      default: alu = a & opb;
    endcase
  end
  // f3[2] selects less-than vs equality, f3[1] unsigned, f3[0] inverts the sense.
  assign cond = (f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b) ^ f3[0];
  assign taken = is_jal || is_jalr || (is_br && cond);
  assign target = is_jalr ? (a + imm) & ~32'd1 : pc + imm;
  assign ea = a + imm;
  assign wb_val = op == OP_LUI ? imm : op == OP_AUIPC ? pc + imm : (is_jal || is_jalr) ? pc + 32'd4 : alu;
  assign x_trap = (taken && target[1:0] != 2'b00) || ((is_ld || is_st) && ea[1:0] != 2'b00);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      retire <= 1'b0;
      halted <= 1'b0;
      illegal <= 1'b0;
      ir <= '0;
      a <= '0;
      b <= '0;
      imm <= '0;
      res <= '0;
      npc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        IDLE: begin
          state <= FETCH;
          mem_req <= 1'b1;
          mem_addr <= pc;
        end
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          mem_req <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          a <= rf[rs1];
          b <= rf[rs2];
          imm <= imm_d;
          if (ir == 32'h0000_0073) begin
            state <= HALT;
            halted <= 1'b1;
          end else if (!legal || bad_reg) begin
            state <= TRAP;
            halted <= 1'b1;
            illegal <= 1'b1;
          end else state <= EXEC;
        end
        EXEC: begin
          npc <= taken ? target : pc + 32'd4;
          if (x_trap) begin
            state <= TRAP;
            halted <= 1'b1;
            illegal <= 1'b1;
          end else if (is_ld || is_st) begin
            state <= MEM;
            mem_req <= 1'b1;
            mem_we <= is_st;
            mem_addr <= ea;
            mem_wdata <= b;
          end else begin
            state <= WB;
            retire <= 1'b1;
            res <= wb_val;
          end
        end
        MEM: if (mem_ready) begin
          res <= mem_rdata;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          retire <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (use_rd && rd != 5'd0) rf[rd] <= res;
          pc <= npc;
          mem_addr <= npc;
          mem_req <= 1'b1;
          state <= FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed self-checking bench for multi_cycle_cpu
module tb_multi_cycle_cpu;
  localparam logic [6:0] OPI = 7'b0010011, LOAD = 7'b0000011;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic mem_req, mem_we, mem_ready, retire, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic m16_req, m16_we, m16_retire, m16_halted, m16_illegal;
  logic m16_ready = 1'b1;
  logic [31:0] m16_addr, m16_wdata, m16_rdata, m16_pc;
  logic [31:0] prog [256];
  logic [31:0] mem [256];
  logic [31:0] mem16 [16];
  logic stall_data = 1'b0, hold_en = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  int wait_cnt = 0, cyc = 0, st_cnt = 0, dreq_cnt = 0, unstable = 0;
  logic [31:0] st_addr = 32'h0, st_data = 32'h0, p_addr = 32'h0, p_wdata = 32'h0;
  logic p_we = 1'b0, pend = 1'b0;
  int ret_cyc [$];
  logic [31:0] ret_pc [$];
  int checks = 0, fails = 0;

  multi_cycle_cpu #(.RESET_PC(32'h0), .NREGS(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .retire(retire), .halted(halted), .illegal(illegal));

  multi_cycle_cpu #(.RESET_PC(32'h0), .NREGS(16), .XLEN(32)) dut16 (
    .clk(clk), .rst(rst), .mem_req(m16_req), .mem_we(m16_we), .mem_addr(m16_addr),
    .mem_wdata(m16_wdata), .mem_ready(m16_ready), .mem_rdata(m16_rdata), .pc(m16_pc),
    .retire(m16_retire), .halted(m16_halted), .illegal(m16_illegal));

  assign mem_rdata = mem[mem_addr[9:2]];
  assign m16_rdata = mem16[m16_addr[5:2]];
  always_comb mem_ready = !((stall_data && mem_addr >= 32'h40 && wait_cnt < 3) || (hold_en && mem_addr == hold_addr));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wait_cnt <= 0;
    end else begin
      if (mem_req && mem_we && mem_ready) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        st_addr <= mem_addr;
        st_data <= mem_wdata;
        st_cnt <= st_cnt + 1;
      end
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
      if (mem_req && mem_addr >= 32'h40) dreq_cnt <= dreq_cnt + 1;
      if (pend && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata)) unstable <= unstable + 1;
      if (retire) begin ret_cyc.push_back(cyc); ret_pc.push_back(pc); end
    end
    pend <= rst && mem_req && !mem_ready;
    p_addr <= mem_addr;
    p_we <= mem_we;
    p_wdata <= mem_wdata;
  end

  function automatic logic [31:0] ei(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] er(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] es(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] eb(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] ej(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_prog;
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic run(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    clear_prog;
    prog[0] = ei(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pc !== 32'h0) begin fails++; $display("FAIL reset pc: got %h want %h", pc, 32'h0); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset mem_req/we: got %b%b want 00", mem_req, mem_we); end
    checks++; if ({retire, halted, illegal} !== 3'b000) begin fails++; $display("FAIL reset flags: got %b want 000", {retire, halted, illegal}); end
    checks++; if (dut.rf[7] !== 32'h0) begin fails++; $display("FAIL reset x7: got %h want 0", dut.rf[7]); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL idle mem_req: got %b want 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin fails++; $display("FAIL first fetch: got req=%b we=%b addr=%h want 1 0 0", mem_req, mem_we, mem_addr); end
  endtask

  task automatic test_alu;
    bit ok;
    int n0;
    clear_prog;
    prog[0] = ei(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    prog[1] = ei(12'hFF9, 5'd1, 3'd0, 5'd2, OPI);
    prog[2] = 32'h0000_0073;
    do_reset;
    n0 = ret_cyc.size();
    run(100, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL alu halt timeout: got %b want 1", ok); end
    checks++; if (dut.rf[1] !== 32'd5) begin fails++; $display("FAIL alu x1: got %h want 5", dut.rf[1]); end
    checks++; if (dut.rf[2] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL alu x2: got %h want fffffffe", dut.rf[2]); end
    checks++; if (pc !== 32'h8 || illegal !== 1'b0) begin fails++; $display("FAIL alu halt pc/illegal: got %h %b want 8 0", pc, illegal); end
    checks++; if (ret_cyc.size() - n0 !== 2) begin fails++; $display("FAIL alu retire count: got %0d want 2", ret_cyc.size() - n0); end
    else begin
      checks++; if (ret_cyc[n0+1] - ret_cyc[n0] !== 4) begin fails++; $display("FAIL alu retire spacing: got %0d want 4", ret_cyc[n0+1] - ret_cyc[n0]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b0 || pc !== 32'h8 || halted !== 1'b1) begin fails++; $display("FAIL halt hold: got req=%b pc=%h halted=%b want 0 8 1", mem_req, pc, halted); end
  endtask

  task automatic test_mem_stall;
    bit ok;
    int n0, s0, u0;
    clear_prog;
    prog[0] = ei(12'hFFE, 5'd0, 3'd0, 5'd2, OPI);
    prog[1] = es(12'h040, 5'd2, 5'd0);
    prog[2] = ei(12'h040, 5'd0, 3'b010, 5'd3, LOAD);
    prog[3] = 32'h0000_0073;
    stall_data = 1'b1;
    s0 = st_cnt;
    u0 = unstable;
    do_reset;
    n0 = ret_cyc.size();
    run(200, ok);
    stall_data = 1'b0;
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL mem halt timeout: got %b want 1", ok); end
    checks++; if (st_cnt - s0 !== 1 || st_addr !== 32'h40 || st_data !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mem store: got n=%0d addr=%h data=%h want 1 40 fffffffe", st_cnt - s0, st_addr, st_data); end
    checks++; if (dut.rf[3] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mem load x3: got %h want fffffffe", dut.rf[3]); end
    checks++; if (unstable - u0 !== 0) begin fails++; $display("FAIL mem stall stability: got %0d changes want 0", unstable - u0); end
    checks++; if (ret_cyc.size() - n0 !== 3) begin fails++; $display("FAIL mem retire count: got %0d want 3", ret_cyc.size() - n0); end
    else begin
      checks++; if (ret_cyc[n0+1] - ret_cyc[n0] !== 8) begin fails++; $display("FAIL sw latency: got %0d want 8", ret_cyc[n0+1] - ret_cyc[n0]); end
      checks++; if (ret_cyc[n0+2] - ret_cyc[n0+1] !== 8) begin fails++; $display("FAIL lw latency: got %0d want 8", ret_cyc[n0+2] - ret_cyc[n0+1]); end
    end
  endtask

  task automatic test_loop;
    bit ok;
    int n0, nb;
    clear_prog;
    prog[0] = ei(12'd3, 5'd0, 3'd0, 5'd1, OPI);
    prog[1] = ei(12'hFFF, 5'd1, 3'd0, 5'd1, OPI);
    prog[2] = eb(13'h1FFC, 5'd0, 5'd1, 3'b001);
    prog[3] = 32'h0000_0073;
    do_reset;
    n0 = ret_pc.size();
    run(200, ok);
    nb = 0;
    for (int i = n0; i < ret_pc.size(); i++) if (ret_pc[i] == 32'h8) nb++;
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL loop halt timeout: got %b want 1", ok); end
    checks++; if (dut.rf[1] !== 32'h0 || pc !== 32'hC) begin fails++; $display("FAIL loop end: got x1=%h pc=%h want 0 c", dut.rf[1], pc); end
    checks++; if (nb !== 3 || ret_pc.size() - n0 !== 7) begin fails++; $display("FAIL loop retires: got bne=%0d total=%0d want 3 7", nb, ret_pc.size() - n0); end
  endtask

  task automatic test_shift_slt;
    bit ok;
    clear_prog;
    prog[0] = ei(12'd1, 5'd0, 3'd0, 5'd5, OPI);
    prog[1] = ei(12'd31, 5'd5, 3'b001, 5'd5, OPI);
    prog[2] = ei(12'h41F, 5'd5, 3'b101, 5'd4, OPI);
    prog[3] = ei(12'hFFF, 5'd0, 3'd0, 5'd6, OPI);
    prog[4] = ei(12'd1, 5'd0, 3'd0, 5'd7, OPI);
    prog[5] = er(7'h00, 5'd6, 5'd7, 3'b011, 5'd8);
    prog[6] = er(7'h00, 5'd7, 5'd6, 3'b011, 5'd9);
    prog[7] = er(7'h00, 5'd7, 5'd6, 3'b010, 5'd10);
    prog[8] = 32'h0000_0073;
    do_reset;
    run(200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL shift halt timeout: got %b want 1", ok); end
    checks++; if (dut.rf[5] !== 32'h8000_0000) begin fails++; $display("FAIL slli x5: got %h want 80000000", dut.rf[5]); end
    checks++; if (dut.rf[4] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL srai x4: got %h want ffffffff", dut.rf[4]); end
    checks++; if (dut.rf[8] !== 32'd1) begin fails++; $display("FAIL sltu 1<ffffffff: got %h want 1", dut.rf[8]); end
    checks++; if (dut.rf[9] !== 32'd0) begin fails++; $display("FAIL sltu ffffffff<1: got %h want 0", dut.rf[9]); end
    checks++; if (dut.rf[10] !== 32'd1) begin fails++; $display("FAIL slt -1<1: got %h want 1", dut.rf[10]); end
  endtask

  task automatic test_jump;
    bit ok;
    clear_prog;
    prog[0] = {20'h12345, 5'd11, 7'b0110111};
    prog[1] = ej(21'd8, 5'd12);
    prog[2] = ei(12'd1, 5'd0, 3'd0, 5'd13, OPI);
    prog[3] = {20'h00000, 5'd14, 7'b0010111};
    prog[4] = ei(12'd12, 5'd14, 3'd0, 5'd14, 7'b1100111);
    prog[5] = ei(12'd2, 5'd0, 3'd0, 5'd13, OPI);
    prog[6] = er(7'h20, 5'd12, 5'd11, 3'd0, 5'd15);
    prog[7] = 32'h0000_0073;
    do_reset;
    run(200, ok);
    checks++; if (ok !== 1'b1 || pc !== 32'h1C) begin fails++; $display("FAIL jump halt: got ok=%b pc=%h want 1 1c", ok, pc); end
    checks++; if (dut.rf[11] !== 32'h1234_5000) begin fails++; $display("FAIL lui x11: got %h want 12345000", dut.rf[11]); end
    checks++; if (dut.rf[12] !== 32'h8 || dut.rf[13] !== 32'h0) begin fails++; $display("FAIL jal link/skip: got x12=%h x13=%h want 8 0", dut.rf[12], dut.rf[13]); end
    checks++; if (dut.rf[14] !== 32'h14) begin fails++; $display("FAIL jalr rd=rs1 x14: got %h want 14", dut.rf[14]); end
    checks++; if (dut.rf[15] !== 32'h1234_4FF8) begin fails++; $display("FAIL sub x15: got %h want 12344ff8", dut.rf[15]); end
  endtask

  task automatic test_traps;
    bit ok;
    int d0;
    clear_prog;
    prog[0] = ei(12'h041, 5'd0, 3'b010, 5'd3, LOAD);
    d0 = dreq_cnt;
    do_reset;
    run(50, ok);
    checks++; if (ok !== 1'b1 || illegal !== 1'b1) begin fails++; $display("FAIL misaligned lw trap: got halted=%b illegal=%b want 1 1", ok, illegal); end
    checks++; if (dreq_cnt - d0 !== 0 || pc !== 32'h0) begin fails++; $display("FAIL misaligned lw no access: got reqs=%0d pc=%h want 0 0", dreq_cnt - d0, pc); end
    clear_prog;
    prog[0] = ei(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    prog[1] = eb(13'd6, 5'd0, 5'd0, 3'b000);
    do_reset;
    run(50, ok);
    checks++; if (ok !== 1'b1 || illegal !== 1'b1 || pc !== 32'h4) begin fails++; $display("FAIL misaligned branch trap: got %b %b pc=%h want 1 1 4", ok, illegal, pc); end
    clear_prog;
    prog[0] = ei(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    prog[1] = 32'h0000_007F;
    do_reset;
    run(50, ok);
    checks++; if (ok !== 1'b1 || illegal !== 1'b1 || pc !== 32'h4) begin fails++; $display("FAIL bad opcode trap: got %b %b pc=%h want 1 1 4", ok, illegal, pc); end
    checks++; if (dut.rf[1] !== 32'd1 || mem_req !== 1'b0) begin fails++; $display("FAIL trap state: got x1=%h req=%b want 1 0", dut.rf[1], mem_req); end
    checks++; if (m16_halted !== 1'b1 || m16_illegal !== 1'b1 || m16_pc !== 32'h4 || m16_req !== 1'b0) begin fails++; $display("FAIL nregs16 trap: got %b %b pc=%h req=%b want 1 1 4 0", m16_halted, m16_illegal, m16_pc, m16_req); end
    checks++; if (dut16.rf[1] !== 32'd3 || dut16.rf[20] !== 32'h0) begin fails++; $display("FAIL nregs16 regs: got x1=%h x20=%h want 3 0", dut16.rf[1], dut16.rf[20]); end
  endtask

  task automatic test_reset_mid_fetch;
    bit ok, seen;
    clear_prog;
    prog[0] = ei(12'd7, 5'd0, 3'd0, 5'd1, OPI);
    prog[1] = ei(12'd9, 5'd0, 3'd0, 5'd0, OPI);
    prog[2] = 32'h0000_0073;
    hold_addr = 32'h8;
    hold_en = 1'b1;
    do_reset;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req && mem_addr == 32'h8;
    end
    repeat (2) @(negedge clk);
    checks++; if (seen !== 1'b1 || mem_req !== 1'b1 || dut.rf[1] !== 32'd7) begin fails++; $display("FAIL stalled fetch setup: got seen=%b req=%b x1=%h want 1 1 7", seen, mem_req, dut.rf[1]); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || pc !== 32'h0 || dut.rf[1] !== 32'h0 || halted !== 1'b0) begin fails++; $display("FAIL mid-fetch reset: got req=%b pc=%h x1=%h halted=%b want 0 0 0 0", mem_req, pc, dut.rf[1], halted); end
    hold_en = 1'b0;
    rst = 1'b1;
    run(100, ok);
    checks++; if (ok !== 1'b1 || pc !== 32'h8 || illegal !== 1'b0) begin fails++; $display("FAIL restart halt: got %b pc=%h illegal=%b want 1 8 0", ok, pc, illegal); end
    checks++; if (dut.rf[1] !== 32'd7 || dut.rf[0] !== 32'h0) begin fails++; $display("FAIL restart regs: got x1=%h x0=%h want 7 0", dut.rf[1], dut.rf[0]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem16[i] = 32'h0;
    mem16[0] = ei(12'd3, 5'd0, 3'd0, 5'd1, OPI);
    mem16[1] = er(7'h00, 5'd2, 5'd1, 3'd0, 5'd20);
    test_reset;
    test_alu;
    test_mem_stall;
    test_loop;
    test_shift_slt;
    test_jump;
    test_traps;
    test_reset_mid_fetch;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
